// File: rtl/selfadpt_trig_stat.sv
// rtl/selfadpt_trig_stat.sv - trigger interval min/max/count statistics for self-adapt calibration
module selfadpt_trig_stat #(
  parameter int CNT_W    = 20,
  parameter int NUM_W    = 16,
  parameter int NUM_TRIG = 256,
  parameter int JIT_TOL  = 2,
  parameter int TIMEOUT  = 1000000
) (
  input  logic             clk250,
  input  logic             rst_n,
  input  logic             cmd_adpt,
  input  logic             trig_pulse,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] interval_min,
  output logic [CNT_W-1:0] interval_max,
  output logic [NUM_W-1:0] trig_cnt,
  output logic             jitter_err,
  output logic             timeout_err
);

  typedef enum logic [1:0] {IDLE, ARM, MEAS, DONE} state_t;

  // Last interval-counter value before a run is declared dead.
  localparam logic [CNT_W-1:0] IC_LAST  = CNT_W'(TIMEOUT - 1);
  // trig_cnt value at which the next recorded interval completes the run.
  localparam logic [NUM_W-1:0] CNT_LAST = NUM_W'(NUM_TRIG - 1);
  localparam logic [CNT_W-1:0] TOL      = CNT_W'(JIT_TOL);

  state_t           state;
  logic             cmd_adpt_q;
  logic [CNT_W-1:0] ic;
  logic             start;

  assign start = cmd_adpt & ~cmd_adpt_q;

  // Delayed copy of the command level for rising-edge detection.
  always_ff @(posedge clk250) begin
    if (!rst_n) cmd_adpt_q <= 1'b0;
    else        cmd_adpt_q <= cmd_adpt;
  end

  // Run sequencer: arm on the first trigger, then collect interval statistics.
  always_ff @(posedge clk250) begin
    if (!rst_n) begin
      state        <= IDLE;
      ic           <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      interval_min <= '0;
      interval_max <= '0;
      trig_cnt     <= '0;
      jitter_err   <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          ic <= '0;
          if (start) begin
            state        <= ARM;
            busy         <= 1'b1;
            interval_min <= '1;
            interval_max <= '0;
            trig_cnt     <= '0;
            jitter_err   <= 1'b0;
            timeout_err  <= 1'b0;
          end
        end
        ARM: begin
          // The first pulse only sets the time reference.
          if (trig_pulse) begin
            ic    <= CNT_W'(1);
            state <= MEAS;
          end else if (ic == IC_LAST) begin
            timeout_err <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b1;
            state       <= DONE;
          end else begin
            ic <= ic + CNT_W'(1);
          end
        end
        MEAS: begin
          // A trigger wins over a coincident timeout.
          if (trig_pulse) begin
            ic <= CNT_W'(1);
            if (ic < interval_min) interval_min <= ic;
            if (ic > interval_max) interval_max <= ic;
            trig_cnt <= trig_cnt + NUM_W'(1);
            if (trig_cnt == CNT_LAST) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end
          end else if (ic == IC_LAST) begin
            timeout_err <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b1;
            state       <= DONE;
          end else begin
            ic <= ic + CNT_W'(1);
          end
        end
        DONE: begin
          state <= IDLE;
          if (trig_cnt == '0) begin
            interval_min <= '0;
            jitter_err   <= 1'b0;
          end else begin
            jitter_err <= (interval_max - interval_min) > TOL;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_selfadpt_trig_stat.sv
// tb/tb_selfadpt_trig_stat.sv - scoreboard bench for selfadpt_trig_stat
module tb_selfadpt_trig_stat;

  localparam int CNT_W = 20;
  localparam int NUM_W = 16;

  typedef struct {
    int dcyc;
    int mn;
    int mx;
    int cnt;
    int jit;
    int to;
  } exp_t;

  logic clk250 = 1'b0;
  always #2 clk250 = ~clk250;

  int cyc = 0;
  always @(posedge clk250) cyc <= cyc + 1;

  logic [1:0]       rst_n;
  logic [1:0]       cmd;
  logic [1:0]       trig;
  logic [1:0]       busy;
  logic [1:0]       done;
  logic [1:0]       jit;
  logic [1:0]       tmo;
  logic [CNT_W-1:0] mn [2];
  logic [CNT_W-1:0] mx [2];
  logic [NUM_W-1:0] cnt [2];

  exp_t q0[$];
  exp_t q1[$];

  int tests = 0;
  int fails = 0;

  // Instance 0: long timeout for interval statistics runs.
  selfadpt_trig_stat #(.CNT_W(CNT_W), .NUM_W(NUM_W), .NUM_TRIG(4), .JIT_TOL(2), .TIMEOUT(1000)) u_dut0 (
    .clk250(clk250), .rst_n(rst_n[0]), .cmd_adpt(cmd[0]), .trig_pulse(trig[0]),
    .busy(busy[0]), .done(done[0]), .interval_min(mn[0]), .interval_max(mx[0]),
    .trig_cnt(cnt[0]), .jitter_err(jit[0]), .timeout_err(tmo[0])
  );

  // Instance 1: short timeout for abort runs.
  selfadpt_trig_stat #(.CNT_W(CNT_W), .NUM_W(NUM_W), .NUM_TRIG(4), .JIT_TOL(2), .TIMEOUT(50)) u_dut1 (
    .clk250(clk250), .rst_n(rst_n[1]), .cmd_adpt(cmd[1]), .trig_pulse(trig[1]),
    .busy(busy[1]), .done(done[1]), .interval_min(mn[1]), .interval_max(mx[1]),
    .trig_cnt(cnt[1]), .jitter_err(jit[1]), .timeout_err(tmo[1])
  );

  task automatic chk(input string name, input int act, input int exp_v);
    tests++;
    if (act !== exp_v) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    end
  endtask

  function automatic bit pop(input int sel, output exp_t e);
    e = '{0, 0, 0, 0, 0, 0};
    if (sel == 0) begin
      if (q0.size() == 0) return 1'b0;
      e = q0.pop_front();
    end else begin
      if (q1.size() == 0) return 1'b0;
      e = q1.pop_front();
    end
    return 1'b1;
  endfunction

  function automatic int qsize(input int sel);
    return (sel == 0) ? q0.size() : q1.size();
  endfunction

  task automatic push(input int sel, input exp_t e);
    if (sel == 0) q0.push_back(e);
    else          q1.push_back(e);
  endtask

  // Monitors: on each done pulse, check timing, then final results one cycle later.
  for (genvar g = 0; g < 2; g++) begin : g_mon
    always begin
      exp_t e;
      int   dc;
      bit   have;
      @(negedge clk250);
      if (done[g] === 1'b1) begin
        dc = cyc;
        chk($sformatf("d%0d_busy_at_done", g), int'(busy[g]), 0);
        have = pop(g, e);
        @(negedge clk250);
        if (!have) begin
          chk($sformatf("d%0d_unexpected_done", g), 1, 0);
        end else begin
          chk($sformatf("d%0d_done_cycle", g), dc, e.dcyc);
          chk($sformatf("d%0d_min", g), int'(mn[g]), e.mn);
          chk($sformatf("d%0d_max", g), int'(mx[g]), e.mx);
          chk($sformatf("d%0d_cnt", g), int'(cnt[g]), e.cnt);
          chk($sformatf("d%0d_jitter", g), int'(jit[g]), e.jit);
          chk($sformatf("d%0d_timeout", g), int'(tmo[g]), e.to);
        end
      end
    end
  end

  task automatic wait_to(input int e);
    while (cyc < e) @(negedge clk250);
  endtask

  // Rising edge of cmd sampled at posedge s; returns at the negedge after s.
  task automatic start(input int sel, output int s, input bit trig_too);
    @(negedge clk250);
    cmd[sel] = 1'b0;
    @(negedge clk250);
    cmd[sel] = 1'b1;
    if (trig_too) trig[sel] = 1'b1;
    s = cyc + 1;
    @(negedge clk250);
    trig[sel] = 1'b0;
    chk($sformatf("d%0d_busy_after_start", sel), int'(busy[sel]), 1);
  endtask

  // Trigger pulse sampled at posedge e.
  task automatic pulse(input int sel, input int e);
    wait_to(e - 1);
    trig[sel] = 1'b1;
    @(negedge clk250);
    trig[sel] = 1'b0;
  endtask

  task automatic drain(input int sel);
    for (int i = 0; i < 2000 && qsize(sel) != 0; i++) @(negedge clk250);
    if (qsize(sel) != 0) begin
      chk($sformatf("d%0d_done_wait_expired", sel), qsize(sel), 0);
      if (sel == 0) q0.delete();
      else          q1.delete();
    end
    repeat (4) @(negedge clk250);
  endtask

  task automatic check_zero(input int sel, input string tag);
    chk($sformatf("d%0d_%s_busy", sel, tag), int'(busy[sel]), 0);
    chk($sformatf("d%0d_%s_done", sel, tag), int'(done[sel]), 0);
    chk($sformatf("d%0d_%s_min", sel, tag), int'(mn[sel]), 0);
    chk($sformatf("d%0d_%s_max", sel, tag), int'(mx[sel]), 0);
    chk($sformatf("d%0d_%s_cnt", sel, tag), int'(cnt[sel]), 0);
    chk($sformatf("d%0d_%s_jit", sel, tag), int'(jit[sel]), 0);
    chk($sformatf("d%0d_%s_tmo", sel, tag), int'(tmo[sel]), 0);
  endtask

  // Full 4-interval run on instance 0: s0 is the reference pulse offset from start.
  task automatic run4(input int s0, input int s1, input int s2, input int s3, input int s4,
                      input int emn, input int emx, input int ejit,
                      input bit glitch, input bit trig_too);
    int s;
    int e;
    start(0, s, trig_too);
    push(0, '{s + s0 + s1 + s2 + s3 + s4, emn, emx, 4, ejit, 0});
    if (glitch) begin
      wait_to(s + 49);
      cmd[0] = 1'b0;
      wait_to(s + 59);
      cmd[0] = 1'b1;
      @(negedge clk250);
      chk("d0_busy_after_reedge", int'(busy[0]), 1);
    end
    e = s + s0; pulse(0, e);
    e += s1;    pulse(0, e);
    e += s2;    pulse(0, e);
    e += s3;    pulse(0, e);
    e += s4;    pulse(0, e);
    drain(0);
  endtask

  initial begin
    int s;
    rst_n = 2'b00;
    cmd   = 2'b00;
    trig  = 2'b00;
    repeat (3) @(negedge clk250);
    check_zero(0, "reset");
    check_zero(1, "reset");
    rst_n = 2'b11;

    // Even spacing, with a trigger in the start cycle that must be ignored.
    run4(100, 100, 100, 100, 100, 100, 100, 0, 1'b0, 1'b1);
    // Spread of 3 exceeds tolerance; a re-edge mid-run must be ignored.
    run4(100, 100, 101, 103, 100, 100, 103, 1, 1'b1, 1'b0);
    // Spread of 2 is within tolerance; max 102 proves results were cleared.
    run4(100, 100, 102, 101, 100, 100, 102, 0, 1'b0, 1'b0);

    // Reset mid-MEAS: outputs clear and no done pulse follows.
    start(0, s, 1'b0);
    pulse(0, s + 100);
    pulse(0, s + 200);
    wait_to(s + 239);
    cmd[0] = 1'b0;
    wait_to(s + 249);
    rst_n[0] = 1'b0;
    @(negedge clk250);
    rst_n[0] = 1'b1;
    check_zero(0, "midrun_reset");
    repeat (1100) @(negedge clk250);
    run4(100, 100, 100, 100, 100, 100, 100, 0, 1'b0, 1'b0);

    // No triggers at all: abort 50 cycles after arming.
    start(1, s, 1'b0);
    push(1, '{s + 50, 0, 0, 0, 0, 1});
    drain(1);

    // One interval of 20, then silence until timeout.
    start(1, s, 1'b0);
    push(1, '{s + 79, 20, 20, 1, 0, 1});
    pulse(1, s + 10);
    pulse(1, s + 30);
    drain(1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
